unified_buffer: RTL and testbench

Banked on-chip scratchpad shared between the DMA engine (DRAM side) and NB processing elements (PE side). It stores DATA_W-bit words in NB independent single-port banks. The DMA sees one flat, bank-interleaved address space. Each PE owns one bank and accesses it with a local address.

---
 rtl/unified_buffer.sv | 111 +++++++++++
 tb/tb_unified_buffer.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/unified_buffer.sv
// unified_buffer
//   Banked scratchpad shared by a DMA engine and NB processing elements.
//   NB single-port banks of 2^ADDR_W words each. The DMA sees a flat,
//   bank-interleaved address space (low BANK_BITS select the bank, the rest
//   select the local word); PE i addresses bank i directly.
//   Per-bank priority: DMA write > DMA read > PE write > PE read. Losers are
//   dropped. Reads return pre-write contents with one cycle of latency, and
//   outputs hold their value unless a read is granted.
//
//   Optional feature macro: UB_MEM_CLEAR_EN
//     defined   - a sampled reset zeroes every word of every bank.
//     undefined - bank contents are untouched by reset (SRAM/FPGA friendly).
//
// Ports
//   clk            rising-edge clock
//   reset          synchronous active-high reset
//   dma_write_en   DMA write request
//   dma_read_en    DMA read request
//   dma_addr       DMA global (interleaved) address
//   dma_data_in    DMA write data
//   dma_data_out   DMA read data, registered
//   pe_read_en     per-PE read request
//   pe_write_en    per-PE write request
//   pe_addr        per-PE local address
//   pe_data_in     per-PE write data
//   pe_data_out    per-PE read data, registered
module unified_buffer #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 10,
  parameter int NB        = 4,
  parameter int BANK_BITS = $clog2(NB)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          dma_write_en,
  input  logic                          dma_read_en,
  input  logic [ADDR_W-1:0]             dma_addr,
  input  logic [DATA_W-1:0]             dma_data_in,
  output logic [DATA_W-1:0]             dma_data_out,
  input  logic [NB-1:0]                 pe_read_en,
  input  logic [NB-1:0]                 pe_write_en,
  input  logic [NB-1:0][ADDR_W-1:0]     pe_addr,
  input  logic [NB-1:0][DATA_W-1:0]     pe_data_in,
  output logic [NB-1:0][DATA_W-1:0]     pe_data_out
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem_q [NB][DEPTH];

  logic [DATA_W-1:0]          dma_data_q;
  logic [NB-1:0][DATA_W-1:0]  pe_data_q;

  logic [BANK_BITS-1:0] dma_bank;
  logic [ADDR_W-1:0]    dma_local;
  logic [NB-1:0]        dma_sel;
  logic [NB-1:0]        dma_hit;
  logic [NB-1:0]        dma_wr_hit;
  logic                 dma_rd_gnt;
  logic [NB-1:0]        pe_wr_gnt;
  logic [NB-1:0]        pe_rd_gnt;

  // Low address bits pick the bank so consecutive DMA addresses rotate banks.
  assign dma_bank  = dma_addr[BANK_BITS-1:0];
  assign dma_local = dma_addr >> BANK_BITS;
  assign dma_sel   = NB'(1) << dma_bank;

  always_comb begin
    dma_hit    = (dma_write_en || dma_read_en) ? dma_sel : '0;
    dma_wr_hit = dma_write_en ? dma_sel : '0;
    // A DMA write suppresses a simultaneous DMA read; the output holds.
    dma_rd_gnt = dma_read_en && !dma_write_en;
    // Any DMA activity on a bank locks that PE out for the cycle; a PE write
    // also suppresses its own read.
    pe_wr_gnt  = pe_write_en & ~dma_hit;
    pe_rd_gnt  = pe_read_en & ~pe_write_en & ~dma_hit;
  end

  // Bank access and registered read ports
  always_ff @(posedge clk) begin
    if (reset) begin
      dma_data_q <= '0;
      pe_data_q  <= '0;
`ifdef UB_MEM_CLEAR_EN
      for (int b = 0; b < NB; b++) begin
        for (int w = 0; w < DEPTH; w++) begin
          mem_q[b][w] <= '0;
        end
      end
`endif
    end else begin
      if (dma_rd_gnt) begin
        dma_data_q <= mem_q[dma_bank][dma_local];
      end
      for (int b = 0; b < NB; b++) begin
        if (dma_wr_hit[b]) begin
          mem_q[b][dma_local] <= dma_data_in;
        end else if (pe_wr_gnt[b]) begin
          mem_q[b][pe_addr[b]] <= pe_data_in[b];
        end
        if (pe_rd_gnt[b]) begin
          pe_data_q[b] <= mem_q[b][pe_addr[b]];
        end
      end
    end
  end

  assign dma_data_out = dma_data_q;
  assign pe_data_out  = pe_data_q;

endmodule

// File: tb/tb_unified_buffer.sv
module tb_unified_buffer;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 10;
  localparam int NB     = 4;
  localparam int DEPTH  = 1 << ADDR_W;

  logic                      clk = 1'b0;
  logic                      reset;
  logic                      dma_write_en, dma_read_en;
  logic [ADDR_W-1:0]         dma_addr;
  logic [DATA_W-1:0]         dma_data_in;
  logic [DATA_W-1:0]         dma_data_out;
  logic [NB-1:0]             pe_read_en, pe_write_en;
  logic [NB-1:0][ADDR_W-1:0] pe_addr;
  logic [NB-1:0][DATA_W-1:0] pe_data_in;
  logic [NB-1:0][DATA_W-1:0] pe_data_out;

  int checks = 0;
  int errors = 0;

  // Reference model: contents per bank plus a "has been written" flag,
  // since power-up contents are undefined.
  logic [DATA_W-1:0] ref_mem   [NB][DEPTH];
  bit                ref_known [NB][DEPTH];
  logic [DATA_W-1:0] exp_dma;
  bit                exp_dma_k = 0;
  logic [DATA_W-1:0] exp_pe    [NB];
  bit                exp_pe_k  [NB];

  unified_buffer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NB(NB)) dut (
    .clk          (clk),
    .reset        (reset),
    .dma_write_en (dma_write_en),
    .dma_read_en  (dma_read_en),
    .dma_addr     (dma_addr),
    .dma_data_in  (dma_data_in),
    .dma_data_out (dma_data_out),
    .pe_read_en   (pe_read_en),
    .pe_write_en  (pe_write_en),
    .pe_addr      (pe_addr),
    .pe_data_in   (pe_data_in),
    .pe_data_out  (pe_data_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [DATA_W-1:0] obs,
                     input logic [DATA_W-1:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic idle();
    dma_write_en = 0; dma_read_en = 0; dma_addr = '0; dma_data_in = '0;
    pe_read_en = '0; pe_write_en = '0; pe_addr = '0; pe_data_in = '0;
  endtask

  // Predict the effect of the current inputs, advance one clock, compare.
  task automatic step();
    int  db, dl;
    bit  dbusy;
    if (reset) begin
      exp_dma = '0; exp_dma_k = 1;
      for (int i = 0; i < NB; i++) begin exp_pe[i] = '0; exp_pe_k[i] = 1; end
`ifdef UB_MEM_CLEAR_EN
      for (int b = 0; b < NB; b++)
        for (int w = 0; w < DEPTH; w++) begin ref_mem[b][w] = '0; ref_known[b][w] = 1; end
`endif
    end else begin
      db    = int'(dma_addr) % NB;
      dl    = int'(dma_addr) / NB;
      dbusy = dma_write_en || dma_read_en;
      // Reads observe the contents before this cycle's writes.
      if (dma_read_en && !dma_write_en) begin
        exp_dma = ref_mem[db][dl]; exp_dma_k = ref_known[db][dl];
      end
      for (int i = 0; i < NB; i++) begin
        if (!(dbusy && db == i) && pe_read_en[i] && !pe_write_en[i]) begin
          exp_pe[i]   = ref_mem[i][pe_addr[i]];
          exp_pe_k[i] = ref_known[i][pe_addr[i]];
        end
      end
      if (dma_write_en) begin
        ref_mem[db][dl] = dma_data_in; ref_known[db][dl] = 1;
      end
      for (int i = 0; i < NB; i++) begin
        if (!(dbusy && db == i) && pe_write_en[i]) begin
          ref_mem[i][pe_addr[i]] = pe_data_in[i]; ref_known[i][pe_addr[i]] = 1;
        end
      end
    end
    @(posedge clk);
    #1;
    if (exp_dma_k) chk("dma_data_out", dma_data_out, exp_dma);
    for (int i = 0; i < NB; i++)
      if (exp_pe_k[i]) chk($sformatf("pe_data_out[%0d]", i), pe_data_out[i], exp_pe[i]);
  endtask

  initial begin
    idle();
    reset = 1;
    for (int i = 0; i < NB; i++) exp_pe_k[i] = 0;
    step(); step();
    chk("reset_dma", dma_data_out, '0);
    for (int i = 0; i < NB; i++) chk($sformatf("reset_pe%0d", i), pe_data_out[i], '0);
    reset = 0;

    // DMA write 0..7 then read back
    for (int i = 0; i < 8; i++) begin
      idle(); dma_write_en = 1; dma_addr = ADDR_W'(i); dma_data_in = 32'hA000 + i; step();
    end
    for (int i = 0; i < 8; i++) begin
      idle(); dma_read_en = 1; dma_addr = ADDR_W'(i); step();
      chk($sformatf("dma_rd%0d", i), dma_data_out, 32'hA000 + i);
    end

    // All PEs write, then all read
    idle();
    for (int i = 0; i < NB; i++) begin
      pe_write_en[i] = 1; pe_addr[i] = ADDR_W'(10'h200 + i); pe_data_in[i] = 32'hB0000 + i;
    end
    step();
    idle();
    for (int i = 0; i < NB; i++) begin
      pe_read_en[i] = 1; pe_addr[i] = ADDR_W'(10'h200 + i);
    end
    step();
    for (int i = 0; i < NB; i++) chk($sformatf("pe_rd%0d", i), pe_data_out[i], 32'hB0000 + i);

    // Cross-view: DMA addr 6 is bank 2 local 1
    idle(); dma_write_en = 1; dma_addr = 10'd6; dma_data_in = 32'hA006; step();
    idle(); pe_read_en[2] = 1; pe_addr[2] = 10'd1; step();
    chk("cross_view", pe_data_out[2], 32'hA006);

    // Conflict on bank 0; bank 1 proceeds in parallel
    idle();
    dma_write_en = 1; dma_addr = 10'd0; dma_data_in = 32'h1111;
    pe_write_en[0] = 1; pe_addr[0] = 10'd0; pe_data_in[0] = 32'h2222;
    pe_write_en[1] = 1; pe_addr[1] = 10'd0; pe_data_in[1] = 32'h3333;
    step();
    idle(); pe_read_en[0] = 1; pe_read_en[1] = 1; step();
    chk("conflict_b0", pe_data_out[0], 32'h1111);
    chk("conflict_b1", pe_data_out[1], 32'h3333);

    // Hold behaviour
    idle(); dma_read_en = 1; dma_addr = 10'd3; step();
    for (int k = 0; k < 3; k++) begin
      idle(); step();
      chk("hold_idle", dma_data_out, 32'hA003);
    end
    idle(); dma_read_en = 1; dma_write_en = 1; dma_addr = 10'd4; dma_data_in = 32'h5555; step();
    chk("hold_rw", dma_data_out, 32'hA003);
    idle(); dma_read_en = 1; dma_addr = 10'd4; step();
    chk("rw_landed", dma_data_out, 32'h5555);

    // Reset in the middle of a write burst
    for (int i = 8; i < 12; i++) begin
      idle(); dma_write_en = 1; dma_addr = ADDR_W'(i); dma_data_in = 32'hD000 + i; step();
    end
    for (int i = 8; i < 12; i++) begin
      idle(); dma_write_en = 1; dma_addr = ADDR_W'(i); dma_data_in = 32'hC000 + i;
      reset = (i == 10);
      step();
      if (i == 10) begin
        chk("mid_reset_dma", dma_data_out, '0);
        for (int p = 0; p < NB; p++) chk($sformatf("mid_reset_pe%0d", p), pe_data_out[p], '0);
      end
    end
    reset = 0;
    idle(); dma_read_en = 1; dma_addr = 10'd10; step();
`ifdef UB_MEM_CLEAR_EN
    chk("reset_dropped_wr", dma_data_out, 32'h0);
`else
    chk("reset_dropped_wr", dma_data_out, 32'hD00A);
`endif
    idle(); dma_read_en = 1; dma_addr = 10'd11; step();
    chk("post_reset_wr", dma_data_out, 32'hC00B);

    // Randomized traffic over a small window so reads hit written words
    for (int n = 0; n < 400; n++) begin
      idle();
      dma_write_en = ($urandom_range(0, 3) == 0);
      dma_read_en  = ($urandom_range(0, 2) == 0);
      dma_addr     = ADDR_W'($urandom_range(0, 63));
      dma_data_in  = $urandom;
      for (int i = 0; i < NB; i++) begin
        pe_write_en[i] = ($urandom_range(0, 2) == 0);
        pe_read_en[i]  = ($urandom_range(0, 1) == 0);
        pe_addr[i]     = ADDR_W'($urandom_range(0, 15));
        pe_data_in[i]  = $urandom;
      end
      reset = ($urandom_range(0, 99) == 0);
      step();
    end
    reset = 0;
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
